// File: rtl/counter_core_pkg.sv
// Shared definitions for counter_core: FSM states, control/status bit
// positions and the register-bank offsets the block is mapped at.
package counter_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned CTRL_W = 32;
    localparam int unsigned STAT_W = 4;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_DIR     = 1;
    localparam int unsigned CTRL_ONESHOT = 2;
    localparam int unsigned CTRL_LOAD    = 3;
    localparam int unsigned CTRL_IRQ_EN  = 4;
    localparam int unsigned CTRL_PRE_LSB = 16;

    localparam int unsigned STAT_RUN  = 0;
    localparam int unsigned STAT_WRAP = 1;
    localparam int unsigned STAT_DONE = 2;

    localparam logic [7:0] REG_CTRL  = 8'h00;
    localparam logic [7:0] REG_LIMIT = 8'h04;
    localparam logic [7:0] REG_LOAD  = 8'h08;
    localparam logic [7:0] REG_STAT  = 8'h0C;

endpackage

// File: rtl/counter_core_if.sv
// Register-bank side bundle of counter_core; the bank drives the master
// modport, the counter consumes the slave modport.
interface counter_core_if
    import counter_core_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic              ctrl_wr;
    logic [CTRL_W-1:0] ctrl_data;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  load_val;
    logic [STAT_W-1:0] stat_clr;
    logic [WIDTH-1:0]  count;
    logic [STAT_W-1:0] status;
    logic              irq;

    modport master (
        output ctrl_wr, ctrl_data, limit, load_val, stat_clr,
        input  count, status, irq
    );

    modport slave (
        input  ctrl_wr, ctrl_data, limit, load_val, stat_clr,
        output count, status, irq
    );
endinterface

// File: rtl/counter_core_tick_gen.sv
// Prescaler for counter_core: emits a one-cycle tick every i_period+1
// enabled cycles, counting from the most recent synchronous clear.
module tick_gen #(
    parameter int unsigned PRE_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [PRE_W-1:0] i_period,
    output logic             o_tick
);
    logic [PRE_W-1:0] r_cnt;
    logic [PRE_W-1:0] w_sum;

    // r_cnt runs downward from 0, so r_cnt + i_period wraps to 0 once
    // i_period cycles have elapsed since the last clear or tick.
    always_comb begin
        w_sum  = r_cnt + i_period;
        o_tick = i_en && !i_clr && (w_sum == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt - PRE_W'(1);
        end
    end
endmodule

// File: rtl/counter_core.sv
// Programmable up/down timer-counter with prescaler, one-shot mode,
// preload, sticky wrap/done status and a level interrupt.
module counter_core
    import counter_core_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PRE_W = 16
) (
    input  logic           ACLK,
    input  logic           ARESET,
    counter_core_if.slave  bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [PRE_W-1:0] r_prescale;
    logic             r_en, r_dir, r_oneshot, r_irq_en;
    logic             r_load_req, r_wrap, r_done, r_irq;

    logic             w_run, w_tick, w_pre_clr, w_step, w_at_term;
    logic             w_set_wrap, w_set_done, w_unused;
    logic [WIDTH-1:0] w_step_val;

    assign w_unused = &{1'b0, bus.ctrl_data[CTRL_PRE_LSB-1:5],
                        bus.stat_clr[0], bus.stat_clr[3]};

    assign w_run     = (r_state == ST_RUN);
    assign w_pre_clr = bus.ctrl_wr || r_load_req || !w_run;

    tick_gen #(.PRE_W(PRE_W)) u_tick (
        .i_clk    (ACLK),
        .i_rst    (ARESET),
        .i_clr    (w_pre_clr),
        .i_en     (w_run),
        .i_period (r_prescale),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_step     = w_run && w_tick && !r_load_req;
        w_at_term  = r_dir ? (r_count == '0) : (r_count >= bus.limit);
        w_set_wrap = w_step && w_at_term && !r_oneshot;
        w_set_done = w_step && w_at_term && r_oneshot;
        if (!w_at_term) begin
            w_step_val = r_dir ? r_count - WIDTH'(1) : r_count + WIDTH'(1);
        end else if (r_oneshot) begin
            w_step_val = r_dir ? '0 : bus.limit;
        end else begin
            w_step_val = r_dir ? bus.limit : '0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_prescale <= '0;
            r_en       <= 1'b0;
            r_dir      <= 1'b0;
            r_oneshot  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_load_req <= 1'b0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_load_req <= bus.ctrl_wr && bus.ctrl_data[CTRL_LOAD];
            if (bus.ctrl_wr) begin
                r_en       <= bus.ctrl_data[CTRL_EN];
                r_dir      <= bus.ctrl_data[CTRL_DIR];
                r_oneshot  <= bus.ctrl_data[CTRL_ONESHOT];
                r_irq_en   <= bus.ctrl_data[CTRL_IRQ_EN];
                r_prescale <= bus.ctrl_data[CTRL_PRE_LSB +: PRE_W];
            end

            if (r_load_req) begin
                r_count <= bus.load_val;
                r_state <= r_en ? ST_RUN : ST_IDLE;
            end else if (w_step) begin
                r_count <= w_step_val;
                if (w_set_done) r_state <= ST_DONE;
            end

            // A control write's enable decision takes precedence over the load/step outcome.
            if (bus.ctrl_wr) begin
                if (!bus.ctrl_data[CTRL_EN]) r_state <= ST_IDLE;
                else if (r_state == ST_IDLE) r_state <= ST_RUN;
            end

            if (w_set_wrap) r_wrap <= 1'b1;
            else if (bus.stat_clr[STAT_WRAP]) r_wrap <= 1'b0;
            if (w_set_done) r_done <= 1'b1;
            else if (bus.stat_clr[STAT_DONE]) r_done <= 1'b0;

            r_irq <= r_irq_en && (r_wrap || r_done);
        end
    end

    assign bus.count  = r_count;
    assign bus.status = {1'b0, r_done, r_wrap, w_run};
    assign bus.irq    = r_irq;
endmodule

// File: doc/counter_core.md
COUNTER_CORE -- requirements
Module: counter_core

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter and limit width.
REQ-002 SHALL have parameter PRE_W, default 16, prescaler width.
REQ-003 SHALL have port ACLK  in  1  sole clock, all state rising-edge.
REQ-004 SHALL have port ARESET  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port ctrl_wr  in  1  one-cycle strobe, register bank wrote control word (offset 0x0).
REQ-006 SHALL have port ctrl_data  in  32  control word: [0] enable, [1] dir (0 up, 1 down), [2] oneshot, [3] load, [4] irq_en, [31:16] prescale.
REQ-007 SHALL have port limit  in  WIDTH  terminal value (offset 0x4), sampled live every cycle.
REQ-008 SHALL have port load_val  in  WIDTH  preload value (offset 0x8), sampled live.
REQ-009 SHALL have port stat_clr  in  4  one-cycle write-1-to-clear mask for sticky status (offset 0xC write).
REQ-010 SHALL have port count  out  WIDTH  current counter value.
REQ-011 SHALL have port status  out  4  [0] running, [1] wrap sticky, [2] done sticky, [3] reserved 0.
REQ-012 SHALL have port irq  out  1  level interrupt.

Function
REQ-013 SHALL latch enable, dir, oneshot, irq_en and prescale on ctrl_wr; load bit SHALL NOT be stored, acting as a one-cycle load request.
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE->RUN on ctrl_wr with enable=1; RUN->IDLE and DONE->IDLE on ctrl_wr with enable=0.
REQ-016 In RUN a step SHALL occur every prescale+1 cycles; prescale=0 steps every cycle; first step prescale+1 cycles after entering RUN.
REQ-017 Prescaler SHALL clear on entry to RUN, on any ctrl_wr, and in IDLE/DONE.
REQ-018 Up step: count>=limit -> count=0 and set wrap; else count+1.
REQ-019 Down step: count==0 -> count=limit and set wrap; else count-1.
REQ-020 With oneshot=1, the step that would set wrap SHALL instead hold count at terminal value (limit up, 0 down), set done, enter DONE.
REQ-021 limit=0 free-run SHALL hold count at 0 and set wrap every step.
REQ-022 Load request SHALL set count=load_val in the cycle after ctrl_wr, override any same-cycle step, clear prescaler; next state RUN if enable=1 else IDLE (also exits DONE).
REQ-023 count SHALL hold in IDLE and DONE.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH; no carry out exposed.
REQ-025 Simultaneous stat_clr bit and set event on same bit: set wins.
REQ-026 status[0] SHALL be 1 exactly in RUN.
REQ-027 irq SHALL equal irq_en AND (wrap OR done), registered, one cycle after the causing flag.

Reset
REQ-028 ARESET SHALL force state IDLE, count 0, prescaler 0, all latched control 0, status 0, irq 0, asynchronously.
REQ-029 Deassertion SHALL take effect at the next ACLK edge; ARESET mid-RUN SHALL abandon the count with no flag set.

Structure
REQ-030 Package counter_core_pkg SHALL hold state enum, control bit indices, status bit indices, register offsets.
REQ-031 Prescaler SHALL be sub-module tick_gen (PRE_W-bit down counter, one-cycle tick output, synchronous clear).
REQ-032 Block SHALL contain no AXI logic; register bank instantiates it directly.

Verification
REQ-033 ctrl 0x00000001, limit 3, up -> count 0,1,2,3,0 on consecutive cycles; wrap set on 3->0.
REQ-034 ctrl 0x00020001 (prescale 2), limit 10 -> count increments every 3 cycles; 9 cycles after ctrl_wr count==3.
REQ-035 ctrl 0x00000007 (down, oneshot), ctrl 0x0000000F with load_val 5 -> count 5,4,...,0, DONE, done=1, status[0]=0, count stays 0.
REQ-036 irq_en=1, limit 1 free-run -> irq high one cycle after first wrap; stat_clr 0x2 on cycle of next wrap -> wrap stays 1, irq stays high.
REQ-037 RUN at count 7, limit lowered to 4 -> next step count 0, wrap set.
REQ-038 ARESET pulsed 1 ns mid-RUN between edges -> count, status, irq 0 immediately; stays IDLE after release until ctrl_wr.
